mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Iterative multiply/divide unit in the EX stage, with architectural HI/LO registers.
//  Feeds the EX/MEM register with md_result, and with busy so EX/MEM picks md_result over the ALU result.
//  Hazard logic stalls IF/ID/EX while busy=1.
//  Implements MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
// PARAMETERS
//  WIDTH  32  operand, HI and LO width; iteration count of the shift-add / restoring loop
// PORTS
//  clock      in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high; clears all state
//  start      in   1      EX holds a mul/div/hi/lo instruction this cycle
//  md_op      in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MFHI, 101 MFLO, 110 MTHI, 111 MTLO
//  src_a      in   WIDTH  rs operand (multiplicand / dividend / MT* source)
//  src_b      in   WIDTH  rt operand (multiplier / divisor)
//  busy       out  1      unit occupied; new start ignored
//  done       out  1      one-cycle pulse in the cycle HI/LO are written by mul/div
//  md_result  out  WIDTH  combinational: HI if md_op==MFHI, else LO
//  hi, lo     out  WIDTH  architectural HI/LO (debug / forwarding)
// BEHAVIOUR
//  Reset (asynchronous): hi=lo=0, busy=0, done=0, state=IDLE, iteration counter=0, working regs=0.
//  Accept: an operation is accepted on a rising edge with start=1 and busy=0. start with busy=1 is ignored, never queued.
//  MFHI/MFLO: no state change; md_result valid the same cycle.
//  MTHI/MTLO: hi/lo <= src_a on the accepting edge; busy stays 0.
//  MULT/MULTU/DIV/DIVU: operands are latched on the accepting edge.
//   - Signed ops latch magnitudes plus sign flags.
//   - Goes to CALC with counter=WIDTH-1; busy=1 from the next cycle.
//  FSM:
//   - IDLE -> CALC on an accepted mul/div.
//   - CALC: one bit per cycle; counter decrements; CALC -> FIX when counter==0.
//   - FIX: sign correction; writes hi/lo; done=1; -> IDLE. busy=1 in CALC and FIX.
//  Latency: busy high for WIDTH+1 cycles (33 at default). hi/lo are new on the edge ending FIX.
//   - An MFHI issued in the first non-busy cycle sees the new value.
//  Multiply: shift-add over the 2*WIDTH product {hi,lo}.
//   - MULT negates the product when the operand signs differ. MULTU never negates.
//  Divide: restoring algorithm; lo=quotient, hi=remainder.
//   - Signed: quotient is negated if the signs differ; remainder takes the dividend's sign.
//   - 0x80000000 / -1 gives lo=0x80000000, hi=0.
//   - Divisor 0 (signed or unsigned): lo=all-ones, hi=src_a as latched, unmodified. Still takes WIDTH+1 cycles.
//  Reset mid-operation: aborts immediately; hi/lo=0; no done pulse.
//  A start in the same cycle FIX completes is ignored, because busy is still 1.
// CONFIGURATION
//  MUL_DIV_FAST_MUL_EN:
//   - Defined: MULT/MULTU skip CALC and go IDLE -> FIX.
//   - FIX computes a single-cycle WIDTHxWIDTH '*' product, so busy=1 for 1 cycle.
//   - Divide is unchanged.
//  Undefined: iterative shift-add multiply, WIDTH+1 cycles, as above.
// STRUCTURE
//  Shared package md_pkg:
//   - md_op encodings MD_MULT..MD_MTLO.
//   - FSM state encoding S_IDLE/S_CALC/S_FIX.
//  Sub-module md_div_iter: one restoring-division step, combinational:
//   - in:  rem, quo, divisor
//   - out: next rem, next quo
//   - instantiated once inside the CALC datapath.
// TESTING
//  1. MULT a=0xFFFFFFFF, b=2 -> busy 33 cycles, done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFFE.
//  2. MULTU a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE.
//     DIVU a=100, b=7 -> lo=14, hi=2.
//  3. DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
//  4. DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7.
//     DIV a=-5, b=0 -> lo=0xFFFFFFFF, hi=0xFFFFFFFB.
//  5. MTHI src_a=0x12345678, then MFHI next cycle -> md_result=0x12345678, busy never rises.
//     MULT started; MTLO 0xAAAA0000 with start=1 at cycle 5 of busy -> ignored; lo = product.
//  6. Reset asserted at cycle 10 of DIV -> busy=0 and hi=lo=0 immediately; no done.
//     Fresh DIVU 9/3 afterwards -> lo=3, hi=0.
//     With MUL_DIV_FAST_MUL_EN: MULTU 3*5 -> busy 1 cycle, lo=15.

Source files
------------

// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - mul/div operation encodings and FSM state encoding shared by the mul/div unit.
package md_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'b000,
      MD_MULTU = 3'b001,
      MD_DIV   = 3'b010,
      MD_DIVU  = 3'b011,
      MD_MFHI  = 3'b100,
      MD_MFLO  = 3'b101,
      MD_MTHI  = 3'b110,
      MD_MTLO  = 3'b111
   } md_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_e;

endpackage

// File: rtl/md_div_iter.sv
// rtl/md_div_iter.sv - one combinational restoring-division step on magnitudes.
module md_div_iter #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;
   logic             fits;

   // The dividend sits in quo and shifts into rem MSB-first while quotient bits fill from the LSB.
   always_comb begin
      shifted  = {rem, quo[WIDTH-1]};
      fits     = (shifted >= {1'b0, divisor});
      diff     = shifted[WIDTH-1:0] - divisor;
      rem_next = fits ? diff : shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], fits};
   end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative multiply/divide unit with architectural HI/LO registers.
// Optional MUL_DIV_FAST_MUL_EN: single-cycle '*' multiply that bypasses the iterative loop.
module mul_div_unit
   import md_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       md_op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] md_result,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   state_e             state, state_next;
   logic [CW-1:0]      count;
   logic [WIDTH-1:0]   work_hi, work_lo, opnd;
   logic               is_div, neg_hi, neg_lo;

   logic               accept, op_signed, sign_a, sign_b;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH-1:0]   div_rem, div_quo;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] prod_mag, prod;
   logic [WIDTH-1:0]   quo_fix, rem_fix, fix_hi, fix_lo;

   assign accept    = start && (state == S_IDLE);
   assign op_signed = ~md_op[0];
   assign sign_a    = op_signed & src_a[WIDTH-1];
   assign sign_b    = op_signed & src_b[WIDTH-1];
   assign mag_a     = sign_a ? -src_a : src_a;
   assign mag_b     = sign_b ? -src_b : src_b;

   assign busy      = (state != S_IDLE);
   assign done      = (state == S_FIX);
   assign md_result = (md_op == MD_MFHI) ? hi : lo;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (accept && !md_op[2]) begin
`ifdef MUL_DIV_FAST_MUL_EN
               state_next = md_op[1] ? S_CALC : S_FIX;
`else
               state_next = S_CALC;
`endif
            end
         end
         S_CALC:  if (count == '0) state_next = S_FIX;
         S_FIX:   state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   md_div_iter #(.WIDTH(WIDTH)) u_div_iter (
      .rem      (work_hi),
      .quo      (work_lo),
      .divisor  (opnd),
      .rem_next (div_rem),
      .quo_next (div_quo)
   );

   // Shift-add step: multiplier in work_lo is consumed LSB-first as the partial sum shifts in from the top.
   assign mul_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : '0);

`ifdef MUL_DIV_FAST_MUL_EN
   assign prod_mag = {{WIDTH{1'b0}}, work_lo} * {{WIDTH{1'b0}}, opnd};
`else
   assign prod_mag = {work_hi, work_lo};
`endif

   // A zero divisor leaves the dividend magnitude in work_hi, so re-signing it restores src_a exactly.
   always_comb begin
      prod    = neg_lo ? -prod_mag : prod_mag;
      quo_fix = neg_lo ? -work_lo : work_lo;
      rem_fix = neg_hi ? -work_hi : work_hi;
      fix_hi  = is_div ? rem_fix : prod[2*WIDTH-1:WIDTH];
      fix_lo  = is_div ? ((opnd == '0) ? '1 : quo_fix) : prod[WIDTH-1:0];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hi      <= '0;
         lo      <= '0;
         count   <= '0;
         work_hi <= '0;
         work_lo <= '0;
         opnd    <= '0;
         is_div  <= 1'b0;
         neg_hi  <= 1'b0;
         neg_lo  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  case (md_op)
                     MD_MTHI: hi <= src_a;
                     MD_MTLO: lo <= src_a;
                     MD_MULT, MD_MULTU: begin
                        is_div  <= 1'b0;
                        count   <= CW'(WIDTH-1);
                        work_hi <= '0;
                        work_lo <= mag_b;
                        opnd    <= mag_a;
                        neg_lo  <= sign_a ^ sign_b;
                        neg_hi  <= 1'b0;
                     end
                     MD_DIV, MD_DIVU: begin
                        is_div  <= 1'b1;
                        count   <= CW'(WIDTH-1);
                        work_hi <= '0;
                        work_lo <= mag_a;
                        opnd    <= mag_b;
                        neg_lo  <= sign_a ^ sign_b;
                        neg_hi  <= sign_a;
                     end
                     default: ;
                  endcase
               end
            end
            S_CALC: begin
               count <= count - 1'b1;
               if (is_div) begin
                  work_hi <= div_rem;
                  work_lo <= div_quo;
               end else begin
                  work_hi <= mul_sum[WIDTH:1];
                  work_lo <= {mul_sum[0], work_lo[WIDTH-1:1]};
               end
            end
            S_FIX: begin
               hi <= fix_hi;
               lo <= fix_lo;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;
   import md_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] src_a, src_b;
   logic        busy, done;
   logic [31:0] md_result, hi, lo;

   int n_checks = 0;
   int n_fail   = 0;

   mul_div_unit #(.WIDTH(32)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .md_op     (md_op),
      .src_a     (src_a),
      .src_b     (src_b),
      .busy      (busy),
      .done      (done),
      .md_result (md_result),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clock = ~clock;

   function automatic void ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi_e, output logic [31:0] lo_e);
      longint      p;
      logic [63:0] u;
      int          q, r;
      hi_e = '0;
      lo_e = '0;
      case (op)
         MD_MULT: begin
            p = longint'($signed(a)) * longint'($signed(b));
            {hi_e, lo_e} = p;
         end
         MD_MULTU: begin
            u = {32'd0, a} * {32'd0, b};
            {hi_e, lo_e} = u;
         end
         MD_DIV: begin
            if (b == 32'd0) begin
               lo_e = 32'hFFFF_FFFF; hi_e = a;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               lo_e = 32'h8000_0000; hi_e = 32'd0;
            end else begin
               q = $signed(a) / $signed(b);
               r = $signed(a) % $signed(b);
               lo_e = q; hi_e = r;
            end
         end
         default: begin
            if (b == 32'd0) begin
               lo_e = 32'hFFFF_FFFF; hi_e = a;
            end else begin
               lo_e = a / b; hi_e = a % b;
            end
         end
      endcase
   endfunction

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int inject_at, input logic [2:0] inj_op, input logic [31:0] inj_a,
                         input string name);
      logic [31:0] hi_e, lo_e;
      int cycles, dones, done_at, lat_e;
      ref_md(op, a, b, hi_e, lo_e);
      lat_e = 33;
`ifdef MUL_DIV_FAST_MUL_EN
      if (!op[1]) lat_e = 1;
`endif
      @(negedge clock);
      start = 1'b1; md_op = op; src_a = a; src_b = b;
      @(negedge clock);
      start = 1'b0;
      cycles = 0; dones = 0; done_at = 0;
      while (busy && cycles < 100) begin
         cycles++;
         if (done) begin dones++; done_at = cycles; end
         if (cycles == inject_at) begin
            start = 1'b1; md_op = inj_op; src_a = inj_a;
         end else begin
            start = 1'b0;
         end
         @(negedge clock);
      end
      start = 1'b0;
      n_checks++; if (cycles !== lat_e) begin n_fail++; $display("FAIL %s busy_cycles op=%0d a=%h b=%h got %0d want %0d", name, op, a, b, cycles, lat_e); end
      n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL %s done_count op=%0d got %0d want 1", name, op, dones); end
      n_checks++; if (done_at !== lat_e) begin n_fail++; $display("FAIL %s done_cycle op=%0d got %0d want %0d", name, op, done_at, lat_e); end
      n_checks++; if (hi !== hi_e) begin n_fail++; $display("FAIL %s hi op=%0d a=%h b=%h got %h want %h", name, op, a, b, hi, hi_e); end
      n_checks++; if (lo !== lo_e) begin n_fail++; $display("FAIL %s lo op=%0d a=%h b=%h got %h want %h", name, op, a, b, lo, lo_e); end
      start = 1'b1; md_op = MD_MFHI;
      #1;
      n_checks++; if (md_result !== hi_e) begin n_fail++; $display("FAIL %s mfhi_result got %h want %h", name, md_result, hi_e); end
      md_op = MD_MFLO;
      #1;
      n_checks++; if (md_result !== lo_e) begin n_fail++; $display("FAIL %s mflo_result got %h want %h", name, md_result, lo_e); end
      start = 1'b0;
   endtask

   task automatic mt_then_mf(input logic [2:0] mt_op, input logic [31:0] val, input string name);
      @(negedge clock);
      start = 1'b1; md_op = mt_op; src_a = val; src_b = $urandom;
      @(negedge clock);
      start = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_after_mt got %b want 0", name, busy); end
      start = 1'b1; md_op = (mt_op == MD_MTHI) ? MD_MFHI : MD_MFLO;
      #1;
      n_checks++; if (md_result !== val) begin n_fail++; $display("FAIL %s mf_result got %h want %h", name, md_result, val); end
      n_checks++; if (((mt_op == MD_MTHI) ? hi : lo) !== val) begin n_fail++; $display("FAIL %s reg_value got %h want %h", name, (mt_op == MD_MTHI) ? hi : lo, val); end
      @(negedge clock);
      start = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_after_mf got %b want 0", name, busy); end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; md_op = MD_MFLO; src_a = '0; src_b = '0;
      repeat (2) @(negedge clock);
      n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL reset busy_done got %b want 00", {busy, done}); end
      n_checks++; if ({hi, lo} !== 64'd0) begin n_fail++; $display("FAIL reset hilo got %h want 0", {hi, lo}); end
      reset = 1'b0;
      @(negedge clock);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy_after_release got %b want 0", busy); end
   endtask

   task automatic test_directed();
      run_op(MD_MULT,  32'hFFFF_FFFF, 32'd2,          0, MD_MFHI, 32'd0, "mult_neg");
      run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2,          0, MD_MFHI, 32'd0, "multu");
      run_op(MD_DIVU,  32'd100,       32'd7,          0, MD_MFHI, 32'd0, "divu");
      run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2,          0, MD_MFHI, 32'd0, "div_neg");
      run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF,  0, MD_MFHI, 32'd0, "div_overflow");
      run_op(MD_DIVU,  32'd7,         32'd0,          0, MD_MFHI, 32'd0, "divu_zero");
      run_op(MD_DIV,   32'hFFFF_FFFB, 32'd0,          0, MD_MFHI, 32'd0, "div_zero_neg");
      run_op(MD_MULTU, 32'd3,         32'd5,          0, MD_MFHI, 32'd0, "multu_small");
   endtask

   task automatic test_hilo_moves();
      mt_then_mf(MD_MTHI, 32'h1234_5678, "mthi");
      mt_then_mf(MD_MTLO, 32'h9ABC_DEF0, "mtlo");
   endtask

   task automatic test_ignore_while_busy();
      logic [2:0] op;
`ifdef MUL_DIV_FAST_MUL_EN
      op = MD_DIVU;
`else
      op = MD_MULT;
`endif
      run_op(op, 32'h1234_5678, 32'hFFFF_0100, 5, MD_MTLO, 32'hAAAA_0000, "ignore_busy");
      run_op(MD_DIVU, 32'd100, 32'd7, 33, MD_MTHI, 32'hDEAD_BEEF, "start_in_fix");
   endtask

   task automatic test_reset_mid_op();
      int dones;
      mt_then_mf(MD_MTHI, 32'h0000_1111, "pre_reset_hi");
      mt_then_mf(MD_MTLO, 32'h0000_2222, "pre_reset_lo");
      @(negedge clock);
      start = 1'b1; md_op = MD_DIV; src_a = 32'd1000; src_b = 32'd3;
      @(negedge clock);
      start = 1'b0;
      for (int i = 1; i < 10; i++) @(negedge clock);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_mid busy_before got %b want 1", busy); end
      reset = 1'b1;
      #1;
      n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL reset_mid busy_done got %b want 00", {busy, done}); end
      n_checks++; if ({hi, lo} !== 64'd0) begin n_fail++; $display("FAIL reset_mid hilo got %h want 0", {hi, lo}); end
      dones = 0;
      repeat (3) begin
         @(negedge clock);
         if (done) dones++;
      end
      reset = 1'b0;
      repeat (40) begin
         @(negedge clock);
         if (done || busy) dones++;
      end
      n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL reset_mid stray_activity got %0d want 0", dones); end
      run_op(MD_DIVU, 32'd9, 32'd3, 0, MD_MFHI, 32'd0, "divu_after_reset");
   endtask

   task automatic test_random();
      logic [2:0]  op;
      logic [31:0] a, b;
      for (int i = 0; i < 30; i++) begin
         op = 3'($urandom_range(0, 3));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = 32'hFFFF_FFFF;
            2: a = 32'h8000_0000;
            3: b = 32'($urandom_range(1, 15));
            default: ;
         endcase
         run_op(op, a, b, 0, MD_MFHI, 32'd0, "random");
      end
   endtask

   task automatic test_back_to_back();
      run_op(MD_MULT, 32'h7FFF_FFFF, 32'h8000_0000, 0, MD_MFHI, 32'd0, "b2b_mult");
      run_op(MD_DIV,  32'd17,        32'hFFFF_FFFB, 0, MD_MFHI, 32'd0, "b2b_div");
      run_op(MD_MULT, 32'h8000_0000, 32'h8000_0000, 0, MD_MFHI, 32'd0, "b2b_mult_min");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_hilo_moves();
      test_ignore_while_busy();
      test_back_to_back();
      test_random();
      test_reset_mid_op();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
